// File: rtl/riscv_pkg.sv
// Shared RISC-V decode constants for the decode stage.
// Opcodes, M-extension funct7, default NOP and buffer states.
package riscv_pkg;

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_REG    = 7'b0110011;
    localparam logic [6:0] OP_AMO    = 7'b0101111;

    localparam logic [6:0] OP_FLW    = 7'b0000111;
    localparam logic [6:0] OP_FSW    = 7'b0100111;
    localparam logic [6:0] OP_FMADD  = 7'b1000011;
    localparam logic [6:0] OP_FMSUB  = 7'b1000111;
    localparam logic [6:0] OP_FNMSUB = 7'b1001011;
    localparam logic [6:0] OP_FNMADD = 7'b1001111;
    localparam logic [6:0] OP_FP     = 7'b1010011;

    localparam logic [6:0] F7_M      = 7'b0000001;

    // addi x0, x0, 0
    localparam logic [31:0] NOP_INSN = 32'h0000_0013;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } buf_state_e;

    // True for every floating-point opcode
    function automatic logic is_f_opcode(input logic [6:0] opc);
        logic res;
        res = 1'b0;
        case (opc)
            OP_FLW, OP_FSW, OP_FMADD, OP_FMSUB,
            OP_FNMSUB, OP_FNMADD, OP_FP: res = 1'b1;
            default: res = 1'b0;
        endcase
        return res;
    endfunction

    // True for the fused multiply-add family (rs3 users)
    function automatic logic is_r4_opcode(input logic [6:0] opc);
        logic res;
        res = 1'b0;
        case (opc)
            OP_FMADD, OP_FMSUB,
            OP_FNMSUB, OP_FNMADD: res = 1'b1;
            default: res = 1'b0;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/decode_stage_if.sv
// Fetch -> decode -> execute handshake bundle.
// master is the fetch/execute environment, slave is the decode stage.
interface decode_stage_if;

    logic        ir_valid;
    logic [31:0] ir;
    logic        ir_ready;
    logic        flush;

    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_ir;
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rs3;
    logic        is_m;
    logic        is_f;
    logic        illegal;

    modport master (
        output ir_valid, ir, flush, out_ready,
        input  ir_ready, out_valid, out_ir, opcode, funct3,
        input  rd, rs1, rs2, rs3, is_m, is_f, illegal
    );

    modport slave (
        input  ir_valid, ir, flush, out_ready,
        output ir_ready, out_valid, out_ir, opcode, funct3,
        output rd, rs1, rs2, rs3, is_m, is_f, illegal
    );

endinterface

// File: rtl/decode_fields.sv
// Pure combinational field extraction for one instruction word.
// Register indices are zeroed where the format has no such field.
module decode_fields
    import riscv_pkg::*;
(
    input  logic [31:0] ir_i,
    output logic [6:0]  opcode_o,
    output logic [2:0]  funct3_o,
    output logic [4:0]  rd_o,
    output logic [4:0]  rs1_o,
    output logic [4:0]  rs2_o,
    output logic [4:0]  rs3_o,
    output logic        is_m_o,
    output logic        is_f_o,
    output logic        illegal_o
);

    logic [6:0] opc;

    assign opc      = ir_i[6:0];
    assign opcode_o = opc;
    assign funct3_o = ir_i[14:12];

    // Classify the opcode and pick which register fields are live
    always_comb begin
        rd_o      = ir_i[11:7];
        rs1_o     = ir_i[19:15];
        rs2_o     = 5'd0;
        rs3_o     = 5'd0;
        is_f_o    = is_f_opcode(opc);
        is_m_o    = (opc == OP_REG) && (ir_i[31:25] == F7_M);
        illegal_o = 1'b0;

        case (opc)
            OP_STORE, OP_BRANCH, OP_FSW: begin
                rd_o  = 5'd0;
                rs2_o = ir_i[24:20];
            end
            OP_LUI, OP_AUIPC, OP_JAL: begin
                rs1_o = 5'd0;
            end
            OP_REG, OP_AMO, OP_FLW, OP_FP: begin
                rs2_o = ir_i[24:20];
            end
            OP_FMADD, OP_FMSUB, OP_FNMSUB, OP_FNMADD: begin
                rs2_o = ir_i[24:20];
                rs3_o = is_r4_opcode(opc) ? ir_i[31:27] : 5'd0;
            end
            OP_IMM, OP_LOAD, OP_JALR: begin
                rd_o = ir_i[11:7];
            end
            default: begin
                illegal_o = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/decode_stage.sv
// Two-entry (head + skid) decode buffer between fetch and execute.
// Head is always decoded; empty head holds NOP_IR.
module decode_stage
    import riscv_pkg::*;
#(
    parameter logic [31:0] NOP_IR = NOP_INSN
) (
    input  logic        iCLK,
    input  logic        iRST,
    input  logic        iIR_VALID,
    input  logic [31:0] iIR,
    output logic        oIR_READY,
    input  logic        iFLUSH,
    output logic        oOUT_VALID,
    input  logic        iOUT_READY,
    output logic [31:0] oIR,
    output logic [6:0]  oOPCODE,
    output logic [2:0]  oFUNCT3,
    output logic [4:0]  oRD,
    output logic [4:0]  oRS1,
    output logic [4:0]  oRS2,
    output logic [4:0]  oRS3,
    output logic        oIS_M,
    output logic        oIS_F,
    output logic        oILLEGAL
);

    buf_state_e  state_q, state_d;
    logic [31:0] head_q, head_d;
    logic [31:0] skid_q, skid_d;
    logic        ready_q, ready_d;
    logic        accept;
    logic        consume;

    assign oOUT_VALID = (state_q != ST_EMPTY);
    assign oIR_READY  = ready_q;
    assign oIR        = head_q;

    assign accept  = iIR_VALID && ready_q;
    assign consume = oOUT_VALID && iOUT_READY;

    // Next state and entry movement; flush overrides everything
    always_comb begin
        state_d = state_q;
        head_d  = head_q;
        skid_d  = skid_q;

        if (iFLUSH) begin
            state_d = ST_EMPTY;
            head_d  = NOP_IR;
            skid_d  = NOP_IR;
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (accept) begin
                        state_d = ST_ONE;
                        head_d  = iIR;
                    end
                end
                ST_ONE: begin
                    if (accept && consume) begin
                        head_d = iIR;
                    end else if (accept) begin
                        state_d = ST_FULL;
                        skid_d  = iIR;
                    end else if (consume) begin
                        state_d = ST_EMPTY;
                        head_d  = NOP_IR;
                    end
                end
                ST_FULL: begin
                    if (consume) begin
                        state_d = ST_ONE;
                        head_d  = skid_q;
                        skid_d  = NOP_IR;
                    end
                end
                default: begin
                    state_d = ST_EMPTY;
                    head_d  = NOP_IR;
                    skid_d  = NOP_IR;
                end
            endcase
        end

        ready_d = (state_d != ST_FULL);
    end

    // Buffer registers; reset empties both entries and closes ready
    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            state_q <= ST_EMPTY;
            head_q  <= NOP_IR;
            skid_q  <= NOP_IR;
            ready_q <= 1'b0;
        end else begin
            state_q <= state_d;
            head_q  <= head_d;
            skid_q  <= skid_d;
            ready_q <= ready_d;
        end
    end

    decode_fields u_fields (
        .ir_i      (head_q),
        .opcode_o  (oOPCODE),
        .funct3_o  (oFUNCT3),
        .rd_o      (oRD),
        .rs1_o     (oRS1),
        .rs2_o     (oRS2),
        .rs3_o     (oRS3),
        .is_m_o    (oIS_M),
        .is_f_o    (oIS_F),
        .illegal_o (oILLEGAL)
    );

endmodule
